// File: rtl/sr_drv_pkg.sv
// -----------------------------------------------------------------------------
// sr_drv_pkg
// Shared types and helpers for the SR flip-flop driver.
//   sr_state_e : driver FSM state encoding (IDLE / DRIVE / CHECK)
//   sr_excite  : SR excitation rule, (target, present Q) -> {S, R}
// -----------------------------------------------------------------------------
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } sr_state_e;

    // Only a change of value needs a drive pulse; a hold request yields {0,0}.
    // S and R can never both be 1 from this function.
    function automatic logic [1:0] sr_excite(input logic tgt, input logic q0);
        logic [1:0] sr;
        sr = 2'b00;
        if (tgt && !q0) begin
            sr = 2'b10;
        end else if (!tgt && q0) begin
            sr = 2'b01;
        end
        return sr;
    endfunction

endpackage

// File: rtl/sr_ff_driver.sv
// -----------------------------------------------------------------------------
// sr_ff_driver
// Drives an external SR flip-flop to a requested value and checks the result
// through the fed-back Q. Each transaction takes three cycles:
// DRIVE (S/R pulse), CHECK (sample feedback), then a done pulse in IDLE, where
// the next request may already be accepted.
//
// Parameters
//   CNT_W      width of txn_cnt / err_cnt
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   req_valid  request present (ignored while busy)
//   req_bit    requested Q value
//   req_ready  high in IDLE
//   S, R       registered drive to the SR flip-flop, never both high
//   Q_fb       Q fed back from the flip-flop
//   busy       high in DRIVE and CHECK
//   done       one-cycle completion pulse
//   err        one-cycle mismatch pulse, coincident with done
//   txn_cnt    completed transactions (wraps)
//   err_cnt    mismatching transactions (saturates)
//
// Build option
//   SR_DRV_CHECK_EN  when defined, the CHECK comparison, err and err_cnt are
//                    implemented; otherwise err and err_cnt are tied to 0.
// -----------------------------------------------------------------------------
module sr_ff_driver
    import sr_drv_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_bit,
    output logic             req_ready,
    output logic             S,
    output logic             R,
    input  logic             Q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    sr_state_e        state_reg, state_next;
    logic             tgt_reg, tgt_next;
    logic             q0_reg, q0_next;
    logic             s_reg, s_next;
    logic             r_reg, r_next;
    logic             done_reg, done_next;
    logic [CNT_W-1:0] txn_cnt_reg, txn_cnt_next;
    logic             accept;

    assign accept = (state_reg == IDLE) && req_valid;

    always_comb begin
        state_next   = state_reg;
        tgt_next     = tgt_reg;
        q0_next      = q0_reg;
        done_next    = 1'b0;
        txn_cnt_next = txn_cnt_reg;
        s_next       = 1'b0;
        r_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    tgt_next   = req_bit;
                    q0_next    = Q_fb;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                state_next = CHECK;
            end
            CHECK: begin
                done_next    = 1'b1;
                txn_cnt_next = txn_cnt_reg + 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // S/R are registered: the pulse is computed from the values being
        // latched so it is present exactly for the DRIVE cycle.
        if (state_next == DRIVE) begin
            {s_next, r_next} = sr_excite(tgt_next, q0_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            tgt_reg     <= 1'b0;
            q0_reg      <= 1'b0;
            s_reg       <= 1'b0;
            r_reg       <= 1'b0;
            done_reg    <= 1'b0;
            txn_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            tgt_reg     <= tgt_next;
            q0_reg      <= q0_next;
            s_reg       <= s_next;
            r_reg       <= r_next;
            done_reg    <= done_next;
            txn_cnt_reg <= txn_cnt_next;
        end
    end

`ifdef SR_DRV_CHECK_EN
    logic             err_reg, err_next;
    logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

    always_comb begin
        err_next     = 1'b0;
        err_cnt_next = err_cnt_reg;
        if ((state_reg == CHECK) && (Q_fb != tgt_reg)) begin
            err_next = 1'b1;
            if (err_cnt_reg != {CNT_W{1'b1}}) begin
                err_cnt_next = err_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign err     = err_reg;
    assign err_cnt = err_cnt_reg;
`else
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg == DRIVE) || (state_reg == CHECK);
    assign S         = s_reg;
    assign R         = r_reg;
    assign done      = done_reg;
    assign txn_cnt   = txn_cnt_reg;

    // accept is kept as a named condition for readability in waveforms
    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_sr_ff_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_ff_driver
// Directed bench for sr_ff_driver (CNT_W=2) closing the loop through an SR
// flip-flop model, with an optional stuck-at override on the feedback.
// -----------------------------------------------------------------------------
module tb_sr_ff_driver;

    localparam int CW = 2;
`ifdef SR_DRV_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_bit = 1'b0;
    logic          req_ready;
    logic          S, R;
    logic          Q_fb;
    logic          busy, done, err;
    logic [CW-1:0] txn_cnt, err_cnt;

    logic q_model;
    logic stuck_en = 1'b0;
    logic stuck_val = 1'b0;
    logic mon_en = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_txn = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    sr_ff_driver #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_ready (req_ready),
        .S         (S),
        .R         (R),
        .Q_fb      (Q_fb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .txn_cnt   (txn_cnt),
        .err_cnt   (err_cnt)
    );

    // SR flip-flop model
    initial q_model = 1'b0;
    always @(posedge clk) begin
        if (S && !R)      q_model <= 1'b1;
        else if (R && !S) q_model <= 1'b0;
    end
    assign Q_fb = stuck_en ? stuck_val : q_model;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
            $display("check %-12s obs=%0d exp=%0d ok", tag, obs, exp);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // S and R must never be high together, reset included
    always @(negedge clk) begin
        if (mon_en) chk("sr_excl", int'(S & R), 0);
    end

    // Called at a negedge with the driver in IDLE; returns at the negedge of
    // the done cycle, so the next call is accepted while done is high.
    task automatic do_txn(input logic b, input logic es, input logic er,
                          input logic eq, input logic mis);
        chk("ready", int'(req_ready), 1);
        req_valid = 1'b1;
        req_bit   = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_bit   = ~b;
        @(negedge clk);
        chk("drv_busy", int'(busy), 1);
        chk("drv_ready", int'(req_ready), 0);
        chk("drv_S", int'(S), int'(es));
        chk("drv_R", int'(R), int'(er));
        req_valid = 1'b1;   // must be ignored while busy
        @(negedge clk);
        chk("chk_SR", int'({S, R}), 0);
        chk("chk_busy", int'(busy), 1);
        chk("chk_Q", int'(Q_fb), int'(eq));
        chk("chk_done", int'(done), 0);
        req_valid = 1'b0;
        @(negedge clk);
        exp_txn = (exp_txn + 1) % (1 << CW);
        if (mis && CHK_EN && exp_err < (1 << CW) - 1) exp_err++;
        chk("done", int'(done), 1);
        chk("err", int'(err), int'(mis && CHK_EN));
        chk("txn_cnt", int'(txn_cnt), exp_txn);
        chk("err_cnt", int'(err_cnt), exp_err);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        // reset state
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_SR", int'({S, R}), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_txn", int'(txn_cnt), 0);
        chk("rst_errc", int'(err_cnt), 0);
        rst = 1'b0;

        // set from 0, reset from 1, set again, then hold at 1
        do_txn(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_txn(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);   // hold; txn_cnt wraps 3->0

        // feedback stuck at 0: five mismatches, err_cnt saturates at 3
        stuck_en  = 1'b1;
        stuck_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_txn(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        stuck_en = 1'b0;

        // reset during DRIVE (model Q is 1 here, request 0 -> R pulse)
        req_valid = 1'b1;
        req_bit   = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("mrst_drv_R", int'(R), 1);
        @(negedge clk);
        exp_txn = 0;
        exp_err = 0;
        chk("mrst_SR", int'({S, R}), 0);
        chk("mrst_ready", int'(req_ready), 1);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_txn", int'(txn_cnt), 0);
        chk("mrst_errc", int'(err_cnt), 0);
        // reset wins over a simultaneous request
        req_valid = 1'b1;
        req_bit   = 1'b1;
        @(negedge clk);
        chk("rpri_ready", int'(req_ready), 1);
        chk("rpri_busy", int'(busy), 0);
        rst       = 1'b0;
        req_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mrst_nodone", int'(done), 0);
            chk("mrst_txn2", int'(txn_cnt), 0);
        end

        // req_valid held for 9 cycles: accepts every third cycle
        acc = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_bit = i[0];
            chk("str_done", int'(done), int'((i % 3 == 0) && (i != 0)));
            if (req_ready) acc++;
            if (i < 8) @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("str_acc", acc, 3);
        chk("str_done9", int'(done), 1);
        chk("str_txn", int'(txn_cnt), 3);
        @(negedge clk);
        chk("str_idle", int'(busy), 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
